// File: rtl/qam_pkg.sv
// Shared encodings for the QAM frame mapper: mode codes, FSM states, bits-per-symbol lookup.
package qam_pkg;

  localparam logic [1:0] MODE_QPSK  = 2'd0;
  localparam logic [1:0] MODE_16QAM = 2'd1;
  localparam logic [1:0] MODE_64QAM = 2'd2;

  localparam logic [2:0] BPS_QPSK  = 3'd2;
  localparam logic [2:0] BPS_16QAM = 3'd4;
  localparam logic [2:0] BPS_64QAM = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  // Reserved mode code 3 falls back to 16QAM.
  function automatic logic [2:0] bps_of(input logic [1:0] mode);
    logic [2:0] bps;
    case (mode)
      MODE_QPSK:  bps = BPS_QPSK;
      MODE_64QAM: bps = BPS_64QAM;
      default:    bps = BPS_16QAM;
    endcase
    return bps;
  endfunction

endpackage

// File: rtl/qam_level_map.sv
// Gray-coded k-bit field (right-aligned in 3 bits) to signed constellation level.
module qam_level_map
  import qam_pkg::*;
#(
  parameter int LEVEL_W  = 9,
  parameter int AMP_STEP = 32
) (
  input  logic        [2:0]         i_gray,
  input  logic        [2:0]         i_bps,
  output logic signed [LEVEL_W-1:0] o_level
);

  logic        [2:0] w_bin;
  logic        [3:0] w_max;
  logic signed [4:0] w_odd;

  // Unused upper Gray bits are zero, so a full 3-bit conversion is valid for any k.
  assign w_bin = {i_gray[2], i_gray[2] ^ i_gray[1], ^i_gray};

  // Largest level index 2**k-1 for the active constellation.
  always_comb begin
    case (i_bps)
      BPS_QPSK:  w_max = 4'd1;
      BPS_64QAM: w_max = 4'd7;
      default:   w_max = 4'd3;
    endcase
  end

  // Odd integer 2L-(2**k-1) lies in -7..7, then scaled by the half level spacing.
  assign w_odd   = $signed({1'b0, w_bin, 1'b0}) - $signed({1'b0, w_max});
  assign o_level = LEVEL_W'(w_odd * AMP_STEP);

endmodule

// File: rtl/qam_frame_mapper.sv
// M-QAM transmit front end: serial bit collection, Gray mapping, preamble + data framing.
//
//  state       | meaning
//  ------------+---------------------------------------------------------------
//  ST_IDLE     | outputs zero, no bits accepted; start on a tick with bit_valid
//  ST_PREAMBLE | PRE_LEN alternating (+A,+A)/(-A,-A) symbols; accumulator prefills
//  ST_DATA     | FRAME_SYMS mapped symbols, (0,0)+underrun when bits are short
module qam_frame_mapper
  import qam_pkg::*;
#(
  parameter int LEVEL_W    = 9,
  parameter int AMP_STEP   = 32,
  parameter int SYM_DIV    = 16,
  parameter int PRE_LEN    = 8,
  parameter int FRAME_SYMS = 64
) (
  input  logic                      carrier_clk,
  input  logic                      reset_n,
  input  logic        [1:0]         mode,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  output logic signed [LEVEL_W-1:0] i_out,
  output logic signed [LEVEL_W-1:0] q_out,
  output logic                      sym_strobe,
  output logic                      frame_start,
  output logic                      underrun,
  output logic                      busy
);

  localparam int DIV_W   = $clog2(SYM_DIV);
  localparam int CNT_MAX = (PRE_LEN > FRAME_SYMS) ? PRE_LEN : FRAME_SYMS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_SYMS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic        [DIV_W-1:0]     r_div_cnt;
  logic        [CNT_W-1:0]     r_sym_cnt;
  logic        [CNT_W-1:0]     w_cnt_nxt;
  logic        [1:0]           r_mode;
  logic        [1:0]           w_mode_nxt;
  logic        [5:0]           r_acc;
  logic        [5:0]           w_acc_nxt;
  logic        [2:0]           r_acc_cnt;
  logic        [2:0]           w_acc_cnt_nxt;
  logic signed [LEVEL_W-1:0]   r_i;
  logic signed [LEVEL_W-1:0]   r_q;
  logic signed [LEVEL_W-1:0]   w_i_nxt;
  logic signed [LEVEL_W-1:0]   w_q_nxt;
  logic                        r_strobe;
  logic                        r_fs;
  logic                        r_ur;
  logic                        w_strobe_nxt;
  logic                        w_fs_nxt;
  logic                        w_ur_nxt;

  logic                        w_tick;
  logic        [2:0]           w_bps;
  logic                        w_accept;
  logic        [2:0]           w_gray_i;
  logic        [2:0]           w_gray_q;
  logic signed [LEVEL_W-1:0]   w_lvl_i;
  logic signed [LEVEL_W-1:0]   w_lvl_q;
  logic        [3:0]           w_amp_mult;
  logic signed [LEVEL_W-1:0]   w_amp;

  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_bps     = bps_of(r_mode);
  assign bit_ready = (r_state != ST_IDLE) && (r_acc_cnt < w_bps);
  assign w_accept  = bit_valid && bit_ready;

  assign i_out       = r_i;
  assign q_out       = r_q;
  assign sym_strobe  = r_strobe;
  assign frame_start = r_fs;
  assign underrun    = r_ur;
  assign busy        = (r_state != ST_IDLE);

  // Split the accumulator into I (older bits) and Q (newer bits) Gray fields.
  always_comb begin
    case (w_bps)
      BPS_QPSK: begin
        w_gray_i = {2'b00, r_acc[1]};
        w_gray_q = {2'b00, r_acc[0]};
      end
      BPS_64QAM: begin
        w_gray_i = r_acc[5:3];
        w_gray_q = r_acc[2:0];
      end
      default: begin
        w_gray_i = {1'b0, r_acc[3:2]};
        w_gray_q = {1'b0, r_acc[1:0]};
      end
    endcase
  end

  qam_level_map #(.LEVEL_W(LEVEL_W), .AMP_STEP(AMP_STEP)) u_map_i (
    .i_gray  (w_gray_i),
    .i_bps   (w_bps),
    .o_level (w_lvl_i)
  );

  qam_level_map #(.LEVEL_W(LEVEL_W), .AMP_STEP(AMP_STEP)) u_map_q (
    .i_gray  (w_gray_q),
    .i_bps   (w_bps),
    .o_level (w_lvl_q)
  );

  // Preamble amplitude is the outermost level of the latched constellation.
  always_comb begin
    case (w_bps)
      BPS_QPSK:  w_amp_mult = 4'd1;
      BPS_64QAM: w_amp_mult = 4'd7;
      default:   w_amp_mult = 4'd3;
    endcase
  end
  assign w_amp = LEVEL_W'($signed({1'b0, w_amp_mult}) * AMP_STEP);

  // Free-running symbol divider; the tick is its terminal count.
  always_ff @(posedge carrier_clk) begin
    if (!reset_n) r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  // FSM state register.
  always_ff @(posedge carrier_clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end

  // Next state, accumulator update and the symbol to present at the coming tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_sym_cnt;
    w_mode_nxt    = r_mode;
    w_i_nxt       = r_i;
    w_q_nxt       = r_q;
    w_strobe_nxt  = 1'b0;
    w_fs_nxt      = 1'b0;
    w_ur_nxt      = 1'b0;
    w_acc_nxt     = r_acc;
    w_acc_cnt_nxt = r_acc_cnt;
    if (w_accept) begin
      w_acc_nxt     = {r_acc[4:0], bit_in};
      w_acc_cnt_nxt = r_acc_cnt + 3'd1;
    end
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_i_nxt = '0;
          w_q_nxt = '0;
          if (bit_valid) begin
            w_mode_nxt  = mode;
            w_state_nxt = ST_PREAMBLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_PREAMBLE: begin
          w_strobe_nxt = 1'b1;
          w_fs_nxt     = (r_sym_cnt == '0);
          w_i_nxt      = r_sym_cnt[0] ? -w_amp : w_amp;
          w_q_nxt      = r_sym_cnt[0] ? -w_amp : w_amp;
          if (r_sym_cnt == PRE_LAST) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_sym_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          w_strobe_nxt = 1'b1;
          if (r_acc_cnt == w_bps) begin
            w_i_nxt       = w_lvl_i;
            w_q_nxt       = w_lvl_q;
            w_acc_nxt     = w_accept ? {5'b0, bit_in} : 6'd0;
            w_acc_cnt_nxt = w_accept ? 3'd1 : 3'd0;
          end else begin
            w_i_nxt  = '0;
            w_q_nxt  = '0;
            w_ur_nxt = 1'b1;
          end
          if (r_sym_cnt == DATA_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_acc_nxt     = '0;
            w_acc_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_sym_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: counters, latched mode, accumulator and outputs.
  always_ff @(posedge carrier_clk) begin
    if (!reset_n) begin
      r_sym_cnt <= '0;
      r_mode    <= MODE_QPSK;
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_i       <= '0;
      r_q       <= '0;
      r_strobe  <= 1'b0;
      r_fs      <= 1'b0;
      r_ur      <= 1'b0;
    end else begin
      r_sym_cnt <= w_cnt_nxt;
      r_mode    <= w_mode_nxt;
      r_acc     <= w_acc_nxt;
      r_acc_cnt <= w_acc_cnt_nxt;
      r_i       <= w_i_nxt;
      r_q       <= w_q_nxt;
      r_strobe  <= w_strobe_nxt;
      r_fs      <= w_fs_nxt;
      r_ur      <= w_ur_nxt;
    end
  end

endmodule
